// File: rtl/wired_commit_seq.sv
// Dual-slot in-order commit sequencer: retires ROB head entries, drains and redirects on flush-causing entries.
// Optional macro WIRED_COMMIT_PERF_EN adds retired_cnt_o, a count of entries retired in RUN.
`ifndef _WIRED_PARAM_ROB_LEN
`define _WIRED_PARAM_ROB_LEN 5
`endif

module wired_commit_seq #(
   parameter int ROB_LEN    = `_WIRED_PARAM_ROB_LEN,
   parameter int INST_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [2*ROB_LEN-1:0]   c_rrrid_o,
   input  logic [1:0]             c_rob_valid_i,
   input  logic [1:0]             c_excp_i,
   input  logic [1:0]             c_need_jump_i,
   input  logic [1:0]             c_uncached_i,
   input  logic [63:0]            c_pc_i,
   input  logic [63:0]            c_target_i,
   input  logic [31:0]            eentry_i,
   input  logic                   stall_i,
   output logic [1:0]             c_retire_o,
   output logic                   flush_o,
   output logic                   redirect_valid_o,
`ifdef WIRED_COMMIT_PERF_EN
   output logic [31:0]            retired_cnt_o,
`endif
   output logic [31:0]            redirect_pc_o
);

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [ROB_LEN-1:0] head_q, head_d;
   logic [31:0]        redirect_pc_q, redirect_pc_d;
   logic               redirect_valid_q, redirect_valid_d;
   logic [1:0]         fc;
   logic [1:0]         retire;
   logic               fc_retire;
   logic [31:0]        slot0_redirect, slot1_redirect;

   function automatic logic [31:0] slot_redirect(input logic excp, input logic jump,
                                                 input logic [31:0] eentry,
                                                 input logic [31:0] target,
                                                 input logic [31:0] pc);
      if (excp)      return eentry;
      else if (jump) return target;
      else           return pc + 32'(INST_BYTES);
   endfunction

   assign fc             = c_excp_i | c_need_jump_i | c_uncached_i;
   assign slot0_redirect = slot_redirect(c_excp_i[0], c_need_jump_i[0], eentry_i,
                                         c_target_i[31:0], c_pc_i[31:0]);
   assign slot1_redirect = slot_redirect(c_excp_i[1], c_need_jump_i[1], eentry_i,
                                         c_target_i[63:32], c_pc_i[63:32]);

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // NOTE: each comb block assigns a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (fc_retire)              state_d = DRAIN;
         DRAIN:   if (c_rob_valid_i == 2'b00) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Output decode: RUN retires in order and stops after the first fc entry; DRAIN retires blindly.
   always_comb begin
      retire  = 2'b00;
      flush_o = 1'b0;
      unique case (state_q)
         RUN: begin
            retire[0] = c_rob_valid_i[0] & ~stall_i;
            retire[1] = c_rob_valid_i[0] & ~stall_i & c_rob_valid_i[1] & ~fc[0];
         end
         DRAIN: begin
            retire[0] = c_rob_valid_i[0];
            retire[1] = c_rob_valid_i[0] & c_rob_valid_i[1];
            flush_o   = 1'b1;
         end
         default: ;
      endcase
   end

   assign fc_retire = (state_q == RUN) && ((retire & fc) != 2'b00);

   always_comb begin
      head_d           = head_q + ROB_LEN'(retire[0]) + ROB_LEN'(retire[1]);
      redirect_valid_d = fc_retire;
      redirect_pc_d    = redirect_pc_q;
      if (fc_retire) redirect_pc_d = (retire[0] & fc[0]) ? slot0_redirect : slot1_redirect;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q           <= '0;
         redirect_pc_q    <= '0;
         redirect_valid_q <= 1'b0;
      end else begin
         head_q           <= head_d;
         redirect_pc_q    <= redirect_pc_d;
         redirect_valid_q <= redirect_valid_d;
      end
   end

   // Retire strobes are combinational from inputs, so they are masked while reset is held.
   assign c_retire_o       = retire & {2{rst_n}};
   assign c_rrrid_o        = {head_q + ROB_LEN'(1), head_q};
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;

`ifdef WIRED_COMMIT_PERF_EN
   logic [31:0] retired_cnt_q, retired_cnt_d;

   always_comb begin
      retired_cnt_d = retired_cnt_q;
      if (state_q == RUN) retired_cnt_d = retired_cnt_q + 32'(retire[0]) + 32'(retire[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retired_cnt_q <= '0;
      else        retired_cnt_q <= retired_cnt_d;
   end

   assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: tb/tb_wired_commit_seq.sv
// Self-checking bench for wired_commit_seq: directed scenarios plus randomized traffic against
// an in-order retire model that scans ROB entries and stops at the first blocking condition.
module tb_wired_commit_seq;

   localparam int ROB_LEN    = 5;
   localparam int INST_BYTES = 4;
   localparam int DEPTH      = 1 << ROB_LEN;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [2*ROB_LEN-1:0] c_rrrid_o;
   logic [1:0]           v, ex, nj, uc;
   logic [31:0]          pc [2];
   logic [31:0]          tgt [2];
   logic [31:0]          ee;
   logic                 st;
   logic [1:0]           c_retire_o;
   logic                 flush_o, redirect_valid_o;
   logic [31:0]          redirect_pc_o;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int          m_head;
   bit          m_drain, m_pulse;
   logic [31:0] m_pc;
   int          nx_head;
   bit          nx_drain, nx_pulse;
   logic [31:0] nx_pc;
   logic [1:0]           exp_retire;
   logic                 exp_flush, exp_rv;
   logic [31:0]          exp_rpc;
   logic [2*ROB_LEN-1:0] exp_rrrid;

   wired_commit_seq #(.ROB_LEN(ROB_LEN), .INST_BYTES(INST_BYTES)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .c_rrrid_o        (c_rrrid_o),
      .c_rob_valid_i    (v),
      .c_excp_i         (ex),
      .c_need_jump_i    (nj),
      .c_uncached_i     (uc),
      .c_pc_i           ({pc[1], pc[0]}),
      .c_target_i       ({tgt[1], tgt[0]}),
      .eentry_i         (ee),
      .stall_i          (st),
      .c_retire_o       (c_retire_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_head = 0; m_drain = 0; m_pulse = 0; m_pc = '0;
   endtask

   // Walk entries head-first; stop at an invalid entry, at a stall in RUN, or after an fc entry in RUN.
   task automatic model_cycle();
      int          n;
      bit          hit;
      logic [31:0] npc;
      n = 0; hit = 0; npc = m_pc;
      exp_rrrid = {ROB_LEN'((m_head + 1) % DEPTH), ROB_LEN'(m_head)};
      exp_flush = m_drain;
      exp_rv    = m_pulse;
      exp_rpc   = m_pc;
      for (int i = 0; i < 2; i++) begin
         if (!v[i] || (!m_drain && st)) break;
         n++;
         if (!m_drain && (ex[i] || nj[i] || uc[i])) begin
            hit = 1;
            npc = ex[i] ? ee : nj[i] ? tgt[i] : pc[i] + 32'(INST_BYTES);
            break;
         end
      end
      exp_retire = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      nx_head  = (m_head + n) % DEPTH;
      nx_pulse = hit;
      nx_pc    = npc;
      nx_drain = hit ? 1'b1 : (m_drain && v == 2'b00) ? 1'b0 : m_drain;
   endtask

   task automatic model_commit();
      m_head = nx_head; m_drain = nx_drain; m_pulse = nx_pulse; m_pc = nx_pc;
   endtask

   task automatic quiet_inputs();
      ex = '0; nj = '0; uc = '0; st = 1'b0;
      pc[0] = $urandom; pc[1] = $urandom; tgt[0] = $urandom; tgt[1] = $urandom;
      ee = 32'h1C00_8000;
   endtask

   task automatic next_cycle();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      quiet_inputs();
      v = 2'b11; nj = 2'b01;
      model_reset();
      #12;
      n_tests++;
      if (c_retire_o !== 2'b00) begin n_fail++; $display("FAIL reset_retire: got %b want 00", c_retire_o); end
      n_tests++;
      if (flush_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_flush_rv: got %b%b want 00", flush_o, redirect_valid_o);
      end
      n_tests++;
      if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_rpc: got %h want 0", redirect_pc_o); end
      n_tests++;
      if (c_rrrid_o !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL reset_rrrid: got %h want %h", c_rrrid_o, {5'd1, 5'd0}); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      quiet_inputs();
   endtask

   task automatic test_clean_pair();
      quiet_inputs(); v = 2'b11;
      #1; model_cycle();
      n_tests++;
      if (c_retire_o !== 2'b11) begin n_fail++; $display("FAIL clean_retire: got %b want 11", c_retire_o); end
      n_tests++;
      if (flush_o !== 1'b0) begin n_fail++; $display("FAIL clean_flush: got %b want 0", flush_o); end
      next_cycle();
      v = 2'b00;
      #1; model_cycle();
      n_tests++;
      if (c_rrrid_o !== {5'd3, 5'd2}) begin n_fail++; $display("FAIL clean_rrrid: got %h want %h", c_rrrid_o, {5'd3, 5'd2}); end
      next_cycle();
   endtask

   task automatic test_stall();
      quiet_inputs(); v = 2'b11; st = 1'b1;
      #1; model_cycle();
      n_tests++;
      if (c_retire_o !== 2'b00) begin n_fail++; $display("FAIL stall_run_retire: got %b want 00", c_retire_o); end
      next_cycle();
      v = 2'b00;
      #1; model_cycle();
      n_tests++;
      if (c_rrrid_o !== exp_rrrid) begin n_fail++; $display("FAIL stall_head_hold: got %h want %h", c_rrrid_o, exp_rrrid); end
      next_cycle();
   endtask

   task automatic test_jump_slot0();
      quiet_inputs(); v = 2'b11; nj = 2'b01; tgt[0] = 32'h1C00_0100;
      #1; model_cycle();
      n_tests++;
      if (c_retire_o !== 2'b01) begin n_fail++; $display("FAIL jump_retire: got %b want 01", c_retire_o); end
      n_tests++;
      if (flush_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL jump_early_flush: got %b%b want 00", flush_o, redirect_valid_o);
      end
      next_cycle();
      // first drain cycle: fc and stall must be ignored
      quiet_inputs(); v = 2'b11; ex = 2'b11; st = 1'b1;
      #1; model_cycle();
      n_tests++;
      if (flush_o !== 1'b1 || redirect_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL jump_pulse: got flush=%b rv=%b want 1 1", flush_o, redirect_valid_o);
      end
      n_tests++;
      if (redirect_pc_o !== 32'h1C00_0100) begin n_fail++; $display("FAIL jump_rpc: got %h want 1c000100", redirect_pc_o); end
      n_tests++;
      if (c_retire_o !== 2'b11) begin n_fail++; $display("FAIL drain_stall_retire: got %b want 11", c_retire_o); end
      next_cycle();
      quiet_inputs(); v = 2'b11;
      #1; model_cycle();
      n_tests++;
      if (redirect_valid_o !== 1'b0 || flush_o !== 1'b1 || c_retire_o !== 2'b11) begin
         n_fail++; $display("FAIL drain_second: got rv=%b flush=%b ret=%b want 0 1 11", redirect_valid_o, flush_o, c_retire_o);
      end
      next_cycle();
      v = 2'b00;
      #1; model_cycle();
      n_tests++;
      if (flush_o !== 1'b1 || c_retire_o !== 2'b00) begin
         n_fail++; $display("FAIL drain_empty: got flush=%b ret=%b want 1 00", flush_o, c_retire_o);
      end
      next_cycle();
      #1; model_cycle();
      n_tests++;
      if (flush_o !== 1'b0) begin n_fail++; $display("FAIL drain_exit: got flush=%b want 0", flush_o); end
      next_cycle();
   endtask

   task automatic test_uncached_excp();
      quiet_inputs(); v = 2'b11; uc = 2'b01; ex = 2'b10; pc[0] = 32'h0000_1000;
      #1; model_cycle();
      n_tests++;
      if (c_retire_o !== 2'b01) begin n_fail++; $display("FAIL unc_retire: got %b want 01", c_retire_o); end
      next_cycle();
      quiet_inputs(); v = 2'b00;
      #1; model_cycle();
      n_tests++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0000_1004) begin
         n_fail++; $display("FAIL unc_rpc: got rv=%b pc=%h want 1 00001004", redirect_valid_o, redirect_pc_o);
      end
      next_cycle();
      #1; model_cycle();
      next_cycle();
   endtask

   task automatic test_wrap();
      quiet_inputs();
      while (m_head != DEPTH - 1) begin
         v = (m_head == DEPTH - 2) ? 2'b01 : 2'b11;
         #1; model_cycle();
         next_cycle();
      end
      v = 2'b11;
      #1; model_cycle();
      n_tests++;
      if (c_rrrid_o !== {5'd0, 5'd31}) begin n_fail++; $display("FAIL wrap_rrrid: got %h want %h", c_rrrid_o, {5'd0, 5'd31}); end
      n_tests++;
      if (c_retire_o !== 2'b11) begin n_fail++; $display("FAIL wrap_retire: got %b want 11", c_retire_o); end
      next_cycle();
      v = 2'b00;
      #1; model_cycle();
      n_tests++;
      if (c_rrrid_o[ROB_LEN-1:0] !== 5'd1) begin n_fail++; $display("FAIL wrap_head: got %0d want 1", c_rrrid_o[ROB_LEN-1:0]); end
      next_cycle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         quiet_inputs();
         v  = 2'($urandom);
         if (m_drain && $urandom_range(0, 2) == 0) v = 2'b00;
         for (int i = 0; i < 2; i++) begin
            ex[i] = ($urandom_range(0, 9) == 0);
            nj[i] = ($urandom_range(0, 7) == 0);
            uc[i] = ($urandom_range(0, 9) == 0);
         end
         st = ($urandom_range(0, 3) == 0);
         ee = $urandom;
         #1; model_cycle();
         n_tests++;
         if (c_retire_o !== exp_retire) begin n_fail++; $display("FAIL rnd_retire c=%0d: got %b want %b", c, c_retire_o, exp_retire); end
         n_tests++;
         if (c_rrrid_o !== exp_rrrid) begin n_fail++; $display("FAIL rnd_rrrid c=%0d: got %h want %h", c, c_rrrid_o, exp_rrrid); end
         n_tests++;
         if (flush_o !== exp_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d: got %b want %b", c, flush_o, exp_flush); end
         n_tests++;
         if (redirect_valid_o !== exp_rv) begin n_fail++; $display("FAIL rnd_rv c=%0d: got %b want %b", c, redirect_valid_o, exp_rv); end
         if (exp_rv) begin
            n_tests++;
            if (redirect_pc_o !== exp_rpc) begin n_fail++; $display("FAIL rnd_rpc c=%0d: got %h want %h", c, redirect_pc_o, exp_rpc); end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_drain();
      quiet_inputs(); v = 2'b11; nj = 2'b01; tgt[0] = 32'h2000_0000;
      #1; model_cycle();
      if (m_drain) v = 2'b00;
      next_cycle();
      while (m_drain) begin
         v = 2'b00;
         #1; model_cycle();
         next_cycle();
      end
      quiet_inputs(); v = 2'b11; nj = 2'b01; tgt[0] = 32'h2000_0000;
      #1; model_cycle();
      next_cycle();
      quiet_inputs(); v = 2'b11;
      #1; model_cycle();
      n_tests++;
      if (flush_o !== 1'b1) begin n_fail++; $display("FAIL mid_drain_entry: got flush=%b want 1", flush_o); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (flush_o !== 1'b0 || c_retire_o !== 2'b00 || redirect_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_drain_async: got flush=%b ret=%b rv=%b want 0 00 0", flush_o, c_retire_o, redirect_valid_o);
      end
      n_tests++;
      if (c_rrrid_o !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL mid_drain_head: got %h want %h", c_rrrid_o, {5'd1, 5'd0}); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      quiet_inputs(); v = 2'b11;
      #1; model_cycle();
      n_tests++;
      if (c_retire_o !== 2'b11 || flush_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_drain_run: got ret=%b flush=%b want 11 0", c_retire_o, flush_o);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_clean_pair();
      test_stall();
      test_jump_slot0();
      test_uncached_excp();
      test_wrap();
      test_random();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wired_commit_seq.md
WIRED_COMMIT_SEQ -- requirements
Module: wired_commit_seq

Interface
REQ-001 SHALL have parameter ROB_LEN, default `_WIRED_PARAM_ROB_LEN, meaning log2 of the ROB depth.
REQ-002 SHALL have parameter INST_BYTES, default 4, meaning the PC increment for the redirect after an uncached op.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 c_rrrid_o  out  2xROB_LEN  ROB read ids: slot0 = head, slot1 = head+1.
REQ-006 c_rob_valid_i  in  2  ROB entry valid per slot.
REQ-007 c_excp_i  in  2  per slot, OR of static and LSU exception flags.
REQ-008 c_need_jump_i  in  2  per slot, branch mispredict / jump required.
REQ-009 c_uncached_i  in  2  per slot, uncached access.
REQ-010 c_pc_i  in  2x32  per-slot PC.
REQ-011 c_target_i  in  2x32  per-slot jump target.
REQ-012 eentry_i  in  32  exception entry address.
REQ-013 stall_i  in  1  store buffer not ready; blocks retire in RUN.
REQ-014 c_retire_o  out  2  per-slot retire strobe to the ROB.
REQ-015 flush_o  out  1  backend flush; also drives the ROB flush_i.
REQ-016 redirect_valid_o  out  1  one-cycle frontend redirect pulse.
REQ-017 redirect_pc_o  out  32  redirect address.

Function
REQ-018 SHALL implement the FSM {RUN, DRAIN}; head_q is a ROB_LEN-bit register.
REQ-019 Head SHALL advance by popcount(c_retire_o) each cycle, modulo 2^ROB_LEN; wrap from 2^ROB_LEN-1 to 0 is silent.
REQ-020 c_rrrid_o SHALL be combinational from head_q; slot1 = head_q+1, with wrap.
REQ-021 An entry is flush-causing (fc) when excp, need_jump or uncached is set.
REQ-022 In RUN, slot0 retire = valid[0] & ~stall_i.
REQ-023 In RUN, slot1 retire = slot0 retire & valid[1] & ~fc[0]; retire is strictly in order.
REQ-024 A retiring fc entry SHALL itself retire, then FSM moves to DRAIN next cycle.
REQ-025 If both slots are fc, only slot0 SHALL retire.
REQ-026 The redirect pc SHALL be latched from the retiring fc entry, in priority: excp -> eentry_i; else need_jump -> target; else uncached -> pc+INST_BYTES.
REQ-027 In the first DRAIN cycle, redirect_valid_o SHALL be 1 with the latched pc; it is 0 in all other cycles.
REQ-028 In DRAIN, flush_o SHALL be 1.
REQ-029 In DRAIN, slot0 retire = valid[0] and slot1 retire = valid[0] & valid[1]; fc and stall_i are ignored.
REQ-030 DRAIN SHALL exit to RUN the cycle after c_rob_valid_i == 2'b00 is sampled; flush_o is 0 in RUN.
REQ-031 Latency: fc retire at cycle N gives flush_o and redirect at N+1.

Reset
REQ-032 On rst_n low, at any time and including mid-DRAIN: state = RUN, head_q = 0, latched pc = 0.
REQ-033 During reset all outputs SHALL be 0, except c_rrrid_o, which SHALL be {1,0}.

Configuration
REQ-034 When macro WIRED_COMMIT_PERF_EN is defined, SHALL add port retired_cnt_o  out  32, counting retired entries in RUN only, wrapping at 2^32, reset 0.
REQ-035 Without WIRED_COMMIT_PERF_EN, the port and counter SHALL be absent and the remaining behaviour is unchanged.

Verification
REQ-036 Clean pair: head=0, valid=11, no fc, stall=0 -> retire=11, next c_rrrid={3,2}, flush=0.
REQ-037 Wrap: ROB_LEN=5, head=31, valid=11 -> c_rrrid={0,31}, retire=11, next head=1.
REQ-038 Jump in slot0: need_jump[0]=1, target=0x1C000100, valid=11 -> retire=01, next cycle flush=1, redirect_valid=1, redirect_pc=0x1C000100; drain retires 2 entries/cycle until valid=00, then RUN.
REQ-039 Exception in slot1 and uncached in slot0: slot0 pc=0x1000 -> retire=01, redirect_pc=0x1004; no slot1 retire in that cycle.
REQ-040 Stall: stall_i=1, valid=11 in RUN -> retire=00; stall_i=1 in DRAIN -> retire continues.
REQ-041 Reset mid-DRAIN: assert rst_n low asynchronously between edges -> flush_o=0 immediately, head=0, RUN after release.
